// File: rtl/data_mem_responder_if.sv
// Load/store request and response handshake between a memory stage and the data-memory responder.
interface data_mem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [1:0]  req_length;
    logic        req_signed;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_error;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, req_length, req_signed, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_error
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, req_length, req_signed, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_error
    );
endinterface

// File: rtl/data_mem_responder.sv
// Single-outstanding data-memory responder: byte-lane RAM, programmable access latency,
// load extension and misalignment/reserved-length error reporting.
module dmr_lane #(
    parameter int ADDR_W = 8
) (
    input  logic              clock,
    input  logic              we,
    input  logic [ADDR_W-1:0] idx,
    input  logic [7:0]        wdata,
    output logic [7:0]        rdata
);
    logic [7:0] mem [2**ADDR_W];

    always_ff @(posedge clock)
        if (we) mem[idx] <= wdata;

    assign rdata = mem[idx];
endmodule

module data_mem_responder #(
    parameter int ADDR_W  = 8,
    parameter int LATENCY = 2
) (
    input  logic               clock,
    input  logic               reset,
    data_mem_responder_if.slave bus
);
    localparam int         NUM_LANES = 4;
    localparam logic [3:0] LAT_M1    = 4'(LATENCY - 1);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    typedef struct packed {
        logic        write;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [1:0]  length;
        logic        sgn;
    } req_t;

    state_t      state;
    logic [3:0]  cnt;
    logic        rdy_q, vld_q, err_q;
    logic [31:0] rdata_q;
    req_t        cur, lat_q, acc;

    assign cur = '{write: bus.req_write, addr: bus.req_addr, wdata: bus.req_wdata,
                   length: bus.req_length, sgn: bus.req_signed};

    // With single-cycle latency the access happens on the acceptance edge itself,
    // so it must use the live request rather than the latched copy.
    assign acc = (LATENCY == 1) ? cur : lat_q;

    logic accept, acc_fire;
    assign accept   = (state == IDLE) && rdy_q && bus.req_valid;
    assign acc_fire = (LATENCY == 1) ? accept : ((state == WAIT) && (cnt == 4'd1));

    logic [ADDR_W-1:0] a_idx;
    logic [1:0]        a_lane;
    logic              a_err;
    assign a_idx  = acc.addr[ADDR_W+1:2];
    assign a_lane = acc.addr[1:0];
    assign a_err  = (acc.length == 2'b11) ||
                    ((acc.length == 2'b01) && acc.addr[0]) ||
                    ((acc.length == 2'b10) && (acc.addr[1:0] != 2'b00));

    logic unused_addr_hi;
    assign unused_addr_hi = ^acc.addr[31:ADDR_W+2];

    logic [NUM_LANES-1:0][7:0] lane_rd, lane_wd;
    logic [NUM_LANES-1:0]      lane_be;

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        always_comb begin
            lane_be[i] = 1'b0;
            lane_wd[i] = acc.wdata[8*i +: 8];
            case (acc.length)
                2'b00: begin
                    lane_be[i] = (a_lane == 2'(i));
                    lane_wd[i] = acc.wdata[7:0];
                end
                2'b01: begin
                    lane_be[i] = (a_lane[1] == 1'(i >> 1));
                    lane_wd[i] = (i % 2 == 1) ? acc.wdata[15:8] : acc.wdata[7:0];
                end
                2'b10:   lane_be[i] = 1'b1;
                default: lane_be[i] = 1'b0;
            endcase
        end

        dmr_lane #(.ADDR_W(ADDR_W)) u_lane (
            .clock (clock),
            .we    (acc_fire && acc.write && !a_err && lane_be[i] && !reset),
            .idx   (a_idx),
            .wdata (lane_wd[i]),
            .rdata (lane_rd[i])
        );
    end

    logic [31:0] rword, ld;
    logic [7:0]  ld_b;
    logic [15:0] ld_h;
    assign rword = lane_rd;
    assign ld_b  = rword[{a_lane, 3'b000} +: 8];
    assign ld_h  = a_lane[1] ? rword[31:16] : rword[15:0];

    always_comb begin
        ld = rword;
        case (acc.length)
            2'b00:   ld = {{24{acc.sgn & ld_b[7]}}, ld_b};
            2'b01:   ld = {{16{acc.sgn & ld_h[15]}}, ld_h};
            default: ld = rword;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            rdy_q   <= 1'b0;
            vld_q   <= 1'b0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            lat_q   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    rdy_q <= 1'b1;
                    if (accept) begin
                        lat_q <= cur;
                        cnt   <= LAT_M1;
                        rdy_q <= 1'b0;
                        if (LATENCY == 1) begin
                            state <= RESP;
                            vld_q <= 1'b1;
                        end else begin
                            state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        state <= RESP;
                        vld_q <= 1'b1;
                    end
                end
                RESP: begin
                    if (bus.resp_ready) begin
                        state   <= IDLE;
                        vld_q   <= 1'b0;
                        rdy_q   <= 1'b1;
                        rdata_q <= '0;
                        err_q   <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
            if (acc_fire) begin
                rdata_q <= (a_err || acc.write) ? 32'h0 : ld;
                err_q   <= a_err;
            end
        end
    end

    assign bus.req_ready  = rdy_q;
    assign bus.resp_valid = vld_q;
    assign bus.resp_rdata = rdata_q;
    assign bus.resp_error = err_q;
endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench: one LATENCY=2 instance for the main plan, one LATENCY=1 instance for latency.
module tb_data_mem_responder;
    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    logic        sel = 1'b0;
    logic        req_valid = 1'b0, req_write = 1'b0, req_signed = 1'b0, resp_ready = 1'b0;
    logic [31:0] req_addr = '0, req_wdata = '0;
    logic [1:0]  req_length = '0;

    data_mem_responder_if if0 ();
    data_mem_responder_if if1 ();

    assign if0.req_valid  = req_valid & ~sel;
    assign if1.req_valid  = req_valid & sel;
    assign if0.resp_ready = resp_ready & ~sel;
    assign if1.resp_ready = resp_ready & sel;
    assign if0.req_write  = req_write;   assign if1.req_write  = req_write;
    assign if0.req_addr   = req_addr;    assign if1.req_addr   = req_addr;
    assign if0.req_wdata  = req_wdata;   assign if1.req_wdata  = req_wdata;
    assign if0.req_length = req_length;  assign if1.req_length = req_length;
    assign if0.req_signed = req_signed;  assign if1.req_signed = req_signed;

    data_mem_responder #(.ADDR_W(8), .LATENCY(2)) dut0 (.clock(clock), .reset(reset), .bus(if0));
    data_mem_responder #(.ADDR_W(8), .LATENCY(1)) dut1 (.clock(clock), .reset(reset), .bus(if1));

    logic        o_req_ready, o_resp_valid, o_resp_error;
    logic [31:0] o_resp_rdata;
    assign o_req_ready  = sel ? if1.req_ready  : if0.req_ready;
    assign o_resp_valid = sel ? if1.resp_valid : if0.resp_valid;
    assign o_resp_rdata = sel ? if1.resp_rdata : if0.resp_rdata;
    assign o_resp_error = sel ? if1.resp_error : if0.resp_error;

    typedef struct {
        logic [31:0] d;
        logic        e;
    } exp_t;
    exp_t sb[$];

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic w, input logic [31:0] a, input logic [31:0] d,
                         input logic [1:0] len, input logic s);
        req_write = w; req_addr = a; req_wdata = d; req_length = len; req_signed = s;
    endtask

    // Returns once the acceptance edge has passed; inputs are then scrambled.
    task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d,
                         input logic [1:0] len, input logic s);
        int n;
        drive(w, a, d, len, s);
        req_valid = 1'b1;
        n = 0;
        while (!o_req_ready && n < 20) begin tick(); n++; end
        chk("accept_ready", {31'b0, o_req_ready}, 32'd1);
        tick();
        req_valid = 1'b0;
        drive(~w, a ^ 32'h4, ~d, len ^ 2'b01, ~s);
    endtask

    task automatic xact(input string tag, input logic w, input logic [31:0] a,
                        input logic [31:0] d, input logic [1:0] len, input logic s,
                        input logic [31:0] exp_d, input logic exp_e, input int hold);
        int n;
        int lat;
        logic [31:0] first;
        exp_t e;
        sb.push_back('{exp_d, exp_e});
        lat = sel ? 1 : 2;
        issue(w, a, d, len, s);
        n = 0;
        while (!o_resp_valid && n < 20) begin tick(); n++; end
        chk({tag, "_latency"}, 32'(n + 1), 32'(lat));
        first = o_resp_rdata;
        for (int k = 0; k < hold; k++) begin
            drive(1'b1, 32'h20, 32'hBAD0BAD0, 2'b10, 1'b0);
            req_valid = 1'b1;
            tick();
            chk({tag, "_hold_valid"}, {31'b0, o_resp_valid}, 32'd1);
            chk({tag, "_hold_rdata"}, o_resp_rdata, first);
            chk({tag, "_hold_ready"}, {31'b0, o_req_ready}, 32'd0);
        end
        req_valid = 1'b0;
        e = sb.pop_front();
        chk({tag, "_rdata"}, o_resp_rdata, e.d);
        chk({tag, "_error"}, {31'b0, o_resp_error}, {31'b0, e.e});
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        chk({tag, "_drop_valid"}, {31'b0, o_resp_valid}, 32'd0);
        chk({tag, "_idle_ready"}, {31'b0, o_req_ready}, 32'd1);
    endtask

    initial begin
        repeat (3) tick();
        chk("rst_req_ready", {31'b0, o_req_ready}, 32'd0);
        chk("rst_resp_valid", {31'b0, o_resp_valid}, 32'd0);
        chk("rst_rdata", o_resp_rdata, 32'd0);
        chk("rst_error", {31'b0, o_resp_error}, 32'd0);
        reset = 1'b0;
        tick();
        chk("post_rst_ready", {31'b0, o_req_ready}, 32'd1);

        xact("st_word",   1, 32'h10, 32'hDEADBEEF, 2'b10, 0, 32'h0,        0, 0);
        xact("ld_word",   0, 32'h10, 32'h0,        2'b10, 0, 32'hDEADBEEF, 0, 0);
        xact("clr_word",  1, 32'h10, 32'h0,        2'b10, 0, 32'h0,        0, 0);
        xact("st_byte",   1, 32'h11, 32'hFFFFFF80, 2'b00, 0, 32'h0,        0, 0);
        xact("ld_sb",     0, 32'h11, 32'h0,        2'b00, 1, 32'hFFFFFF80, 0, 0);
        xact("ld_ub",     0, 32'h11, 32'h0,        2'b00, 0, 32'h00000080, 0, 0);
        xact("ld_w80",    0, 32'h10, 32'h0,        2'b10, 0, 32'h00008000, 0, 0);

        xact("st_w20",    1, 32'h20, 32'h12345678, 2'b10, 0, 32'h0,        0, 0);
        xact("st_half",   1, 32'h22, 32'h9999ABCD, 2'b01, 0, 32'h0,        0, 0);
        xact("ld_sh",     0, 32'h22, 32'h0,        2'b01, 1, 32'hFFFFABCD, 0, 0);
        xact("ld_h_mis",  0, 32'h21, 32'h0,        2'b01, 1, 32'h0,        1, 0);
        xact("st_h_mis",  1, 32'h21, 32'h00001111, 2'b01, 0, 32'h0,        1, 0);
        xact("st_w_mis",  1, 32'h22, 32'h77777777, 2'b10, 0, 32'h0,        1, 0);
        xact("ld_rsv",    0, 32'h20, 32'h0,        2'b11, 0, 32'h0,        1, 0);
        xact("ld_w20",    0, 32'h20, 32'h0,        2'b10, 0, 32'hABCD5678, 0, 0);
        xact("ld_uh",     0, 32'h22, 32'h0,        2'b01, 0, 32'h0000ABCD, 0, 0);
        xact("ld_sb3",    0, 32'h23, 32'h0,        2'b00, 1, 32'hFFFFFFAB, 0, 0);
        xact("ld_ub0",    0, 32'h20, 32'h0,        2'b00, 0, 32'h00000078, 0, 0);
        xact("ld_sb1",    0, 32'h21, 32'h0,        2'b00, 1, 32'h00000056, 0, 0);
        xact("ld_w_sgn",  0, 32'h20, 32'h0,        2'b10, 1, 32'hABCD5678, 0, 0);

        xact("hold",      0, 32'h20, 32'h0,        2'b10, 0, 32'hABCD5678, 0, 5);
        xact("post_hold", 0, 32'h20, 32'h0,        2'b10, 0, 32'hABCD5678, 0, 0);

        xact("st_wrap",   1, 32'h400, 32'hCAFEF00D, 2'b10, 0, 32'h0,        0, 0);
        xact("ld_wrap",   0, 32'h000, 32'h0,        2'b10, 0, 32'hCAFEF00D, 0, 0);

        xact("st_old30",  1, 32'h30, 32'h11223344, 2'b10, 0, 32'h0,        0, 0);
        issue(1, 32'h30, 32'h55667788, 2'b10, 0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("abort_rst_ready", {31'b0, o_req_ready}, 32'd0);
        for (int k = 0; k < 4; k++) begin
            chk("abort_no_valid", {31'b0, o_resp_valid}, 32'd0);
            tick();
        end
        xact("ld_old30",  0, 32'h30, 32'h0,        2'b10, 0, 32'h11223344, 0, 0);

        sel = 1'b1;
        tick();
        xact("l1_st",     1, 32'h40, 32'h0BADF00D, 2'b10, 0, 32'h0,        0, 0);
        xact("l1_ld",     0, 32'h40, 32'h0,        2'b10, 0, 32'h0BADF00D, 0, 0);
        xact("l1_ldb",    0, 32'h43, 32'h0,        2'b00, 1, 32'h0000000B, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
